// File: rtl/spi_transfer_engine.sv
// -----------------------------------------------------------------------------
// spi_transfer_engine
//
// Purpose:
//   Chip-select-framed SPI transfer sequencer. It sits downstream of an SPI
//   clock generator: it drives that generator's enable (clk_enable) and
//   consumes its one-cycle-per-SCLK-period strobe (sync). One accepted start
//   runs one transfer of 1..MAX_WIDTH bits: ss_n falls, CS_SETUP cycles later
//   the clock generator is enabled, len+1 sync pulses move len bits out on
//   mosi and in from miso, the generator is disabled, and CS_HOLD cycles later
//   ss_n rises together with a one-cycle done pulse and a fresh data_out.
//
// Optional feature:
//   SPI_TRANSFER_LSB_FIRST_EN - when defined, bits go out LSB first and the
//   first received bit lands in data_out[0]. Default build is MSB first.
//
// Ports:
//   clockIn          in   system clock
//   reset            in   asynchronous, active-high reset
//   start            in   one-cycle transfer request, honoured only when idle
//   transfer_length  in   bit count; 0 or > MAX_WIDTH means MAX_WIDTH
//   data_in          in   transmit word, right-aligned
//   sync             in   one pulse per SCLK period from the clock generator
//   miso             in   serial receive data
//   mosi             out  serial transmit data
//   ss_n             out  active-low chip select
//   clk_enable       out  enable to the clock generator
//   busy             out  high from the cycle after an accepted start to done
//   data_out         out  last received word, right-aligned, upper bits zero
//   done             out  one-cycle pulse when data_out is updated
// -----------------------------------------------------------------------------
module spi_transfer_engine #(
  parameter int MAX_WIDTH = 32,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2,
  localparam int LW       = $clog2(MAX_WIDTH + 1)
) (
  input  logic                 clockIn,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LW-1:0]        transfer_length,
  input  logic [MAX_WIDTH-1:0] data_in,
  input  logic                 sync,
  input  logic                 miso,
  output logic                 mosi,
  output logic                 ss_n,
  output logic                 clk_enable,
  output logic                 busy,
  output logic [MAX_WIDTH-1:0] data_out,
  output logic                 done
);

  // Framing counter is shared by SETUP and HOLD, so size it for the longer one.
  localparam int CW = (CS_SETUP > CS_HOLD) ? $clog2(CS_SETUP + 1)
                                           : $clog2(CS_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_t;

  state_t               r_state;
  logic [LW-1:0]        r_len;
  logic [LW-1:0]        r_bit_cnt;
  logic [CW-1:0]        r_cnt;
  logic                 r_started;
  logic [MAX_WIDTH-1:0] r_tx;
  logic [MAX_WIDTH-1:0] r_rx;
  logic                 r_mosi;
  logic                 r_ss_n;
  logic                 r_clk_enable;
  logic                 r_busy;
  logic [MAX_WIDTH-1:0] r_data_out;
  logic                 r_done;

  logic [LW-1:0]        w_len;
  logic [LW-1:0]        w_mask_shamt;
  logic [MAX_WIDTH-1:0] w_mask;
  logic                 w_last;
  logic [MAX_WIDTH-1:0] w_tx_load;
  logic [MAX_WIDTH-1:0] w_tx_shifted;
  logic [MAX_WIDTH-1:0] w_rx_shifted;
  logic                 w_first_bit;
  logic                 w_next_bit;

  // Out-of-range lengths collapse to a full-width transfer.
  assign w_len = (transfer_length == '0 || transfer_length > LW'(MAX_WIDTH))
                 ? LW'(MAX_WIDTH) : transfer_length;

  // Receive mask keeps only the low len bits of the shift register.
  assign w_mask_shamt = LW'(MAX_WIDTH) - r_len;
  assign w_mask       = {MAX_WIDTH{1'b1}} >> w_mask_shamt;

  // Current sync completes the final bit.
  assign w_last = (r_bit_cnt == r_len - 1'b1);

`ifdef SPI_TRANSFER_LSB_FIRST_EN
  logic [LW-1:0] w_rx_pos;

  assign w_tx_load    = data_in;
  assign w_tx_shifted = r_tx >> 1;
  assign w_first_bit  = w_tx_load[0];
  assign w_next_bit   = w_tx_shifted[0];
  // New bits enter at position len-1 so the first bit ends up in bit 0.
  assign w_rx_pos     = r_len - 1'b1;
  assign w_rx_shifted = (r_rx >> 1) | ({{(MAX_WIDTH-1){1'b0}}, miso} << w_rx_pos);
`else
  logic [LW-1:0] w_load_shamt;

  // Left-justify the word so the first bit to send sits at the MSB.
  assign w_load_shamt = LW'(MAX_WIDTH) - w_len;
  assign w_tx_load    = data_in << w_load_shamt;
  assign w_tx_shifted = r_tx << 1;
  assign w_first_bit  = w_tx_load[MAX_WIDTH-1];
  assign w_next_bit   = w_tx_shifted[MAX_WIDTH-1];
  assign w_rx_shifted = {r_rx[MAX_WIDTH-2:0], miso};
`endif

  // NOTE: sequential state uses non-blocking (<=) assignments so every
  // register in this block sees the pre-edge value of every other register.
  always_ff @(posedge clockIn or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_len        <= '0;
      r_bit_cnt    <= '0;
      r_cnt        <= '0;
      r_started    <= 1'b0;
      r_tx         <= '0;
      r_rx         <= '0;
      r_mosi       <= 1'b0;
      r_ss_n       <= 1'b1;
      r_clk_enable <= 1'b0;
      r_busy       <= 1'b0;
      r_data_out   <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_len     <= w_len;
            r_tx      <= w_tx_load;
            r_rx      <= '0;
            r_bit_cnt <= '0;
            r_cnt     <= '0;
            r_started <= 1'b0;
            r_mosi    <= w_first_bit;
            r_ss_n    <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= SETUP;
          end
        end

        SETUP: begin
          if (r_cnt == CW'(CS_SETUP - 1)) begin
            r_clk_enable <= 1'b1;
            r_state      <= SHIFT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        SHIFT: begin
          if (sync) begin
            // The first sync only opens bit 0, which mosi already carries.
            if (!r_started) begin
              r_started <= 1'b1;
            end else begin
              r_rx      <= w_rx_shifted;
              r_tx      <= w_tx_shifted;
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (w_last) begin
                // mosi keeps the final bit; nothing past len is driven out.
                r_clk_enable <= 1'b0;
                r_cnt        <= '0;
                r_state      <= HOLD;
              end else begin
                r_mosi <= w_next_bit;
              end
            end
          end
        end

        HOLD: begin
          if (r_cnt == CW'(CS_HOLD - 1)) begin
            r_ss_n     <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_data_out <= r_rx & w_mask;
            r_state    <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign mosi       = r_mosi;
  assign ss_n       = r_ss_n;
  assign clk_enable = r_clk_enable;
  assign busy       = r_busy;
  assign data_out   = r_data_out;
  assign done       = r_done;

endmodule
